div_unit_seq: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops in the riscv-jedro-1 ALU.
//  - One instance of ripple_carry_adder_Nb, sequenced by a small FSM. The FSM time-shares it for

---
 rtl/div_defs.sv | 32 +++
 rtl/ripple_carry_adder_Nb.sv | 32 +++
 rtl/div_unit_seq.sv | 176 +++++++++++++++++
 tb/tb_div_unit_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_defs.sv
// Shared definitions for the sequential divider: op encodings, FSM states
// and small op-decoding helpers.
package div_defs;

    // RV32M divide/remainder op encodings on req_op.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ABS_A = 3'd1,
        S_ABS_B = 3'd2,
        S_CALC  = 3'd3,
        S_FIXUP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // DIV and REM treat their operands as two's-complement numbers.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return !(op inside {OP_DIV, OP_DIVU});
    endfunction

endpackage

// File: rtl/ripple_carry_adder_Nb.sv
// N-bit ripple-carry adder. inv_b_i turns it into a subtractor (a - b via
// a + ~b + 1); ci_i is an extra carry-in for plain addition.
module ripple_carry_adder_Nb #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         inv_b_i,
    input  logic         ci_i,
    output logic [N-1:0] sum_o,
    output logic         co_o
);

    logic carry;
    logic b_bit;

    // Bit-serial carry chain, LSB first.
    always_comb begin
        // NOTE: blocking assignments are intended here; the carry must ripple
        // through the loop within a single evaluation.
        carry = ci_i | inv_b_i;
        b_bit = 1'b0;
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            b_bit    = b_i[i] ^ inv_b_i;
            sum_o[i] = a_i[i] ^ b_bit ^ carry;
            carry    = (a_i[i] & b_bit) | (carry & (a_i[i] ^ b_bit));
        end
        co_o = carry;
    end

endmodule

// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A single N+1 bit adder is time-shared for operand abs, the trial
// subtraction in each CALC step and the final sign fix-up.
module div_unit_seq
    import div_defs::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_data,
    output logic         busy
);

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [N-1:0]     a_q, b_q;
    logic             a_sign_q, b_sign_q;
    logic [N-1:0]     q_q;       // holds |a| after ABS_A, then the quotient
    logic [N-1:0]     rem_q;
    logic [N-1:0]     ub_q;      // |b|
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     resp_data_q;

    logic             accept;
    logic             req_special;
    logic [N-1:0]     special_data;
    logic [N:0]       add_a, add_b, add_sum;
    logic             add_inv, add_co;
    logic             fix_neg;
    logic [N-1:0]     fix_sel;
    logic             unused_sum_msb;

    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign resp_data  = resp_data_q;
    assign accept     = req_valid && req_ready;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned (which would infer a latch).
        req_special  = 1'b0;
        special_data = '0;
        if (req_b == '0) begin
            req_special  = 1'b1;
            special_data = op_is_rem(req_op) ? req_a : '1;
        end else if (op_is_signed(req_op) && req_a == {1'b1, {(N-1){1'b0}}}
                     && req_b == '1) begin
            req_special  = 1'b1;
            special_data = op_is_rem(req_op) ? '0 : req_a;
        end
    end

    // Fix-up selects the requested result and whether it needs negating.
    assign fix_sel = op_is_rem(op_q) ? rem_q : q_q;
    assign fix_neg = op_is_rem(op_q) ? a_sign_q : (a_sign_q ^ b_sign_q);

    // Adder operand mux: all uses are subtractions on zero-extended operands.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_inv = 1'b0;
        case (state_q)
            S_ABS_A: begin
                add_b   = {1'b0, a_q};
                add_inv = 1'b1;
            end
            S_ABS_B: begin
                add_b   = {1'b0, b_q};
                add_inv = 1'b1;
            end
            S_CALC: begin
                add_a   = {rem_q, q_q[N-1]};
                add_b   = {1'b0, ub_q};
                add_inv = 1'b1;
            end
            S_FIXUP: begin
                add_b   = {1'b0, fix_sel};
                add_inv = 1'b1;
            end
            default: ;
        endcase
    end

    ripple_carry_adder_Nb #(.N(N + 1)) u_adder (
        .a_i     (add_a),
        .b_i     (add_b),
        .inv_b_i (add_inv),
        .ci_i    (1'b0),
        .sum_o   (add_sum),
        .co_o    (add_co)
    );

    // Bit N of the sum is never needed; only the carry-out matters there.
    assign unused_sum_msb = add_sum[N];

    // Next-state logic; flush overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_special ? S_DONE : S_ABS_A;
            S_ABS_A: state_d = S_ABS_B;
            S_ABS_B: state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && state_q != S_IDLE) state_d = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; a flush freezes them, keeping resp_data unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: datapath registers are reset too, so a mid-op reset leaves no
        // stale operands or results visible on resp_data.
        if (!rstn) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            q_q         <= '0;
            rem_q       <= '0;
            ub_q        <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else if (!flush) begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q     <= req_op;
                    a_q      <= req_a;
                    b_q      <= req_b;
                    a_sign_q <= op_is_signed(req_op) & req_a[N-1];
                    b_sign_q <= op_is_signed(req_op) & req_b[N-1];
                    if (req_special) resp_data_q <= special_data;
                end
                S_ABS_A: q_q <= a_sign_q ? add_sum[N-1:0] : a_q;
                S_ABS_B: begin
                    ub_q  <= b_sign_q ? add_sum[N-1:0] : b_q;
                    rem_q <= '0;
                    cnt_q <= CNT_W'(N - 1);
                end
                S_CALC: begin
                    if (add_co) begin
                        rem_q <= add_sum[N-1:0];
                        q_q   <= {q_q[N-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[N-2:0], q_q[N-1]};
                        q_q   <= {q_q[N-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIXUP: resp_data_q <= fix_neg ? add_sum[N-1:0] : fix_sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// Self-checking bench for div_unit_seq: directed corner cases, backpressure,
// flush, asynchronous reset and random ops against a reference model.
module tb_div_unit_seq;
    import div_defs::*;

    localparam int N   = 32;
    localparam int LAT = N + 3;
    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rstn;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_a, req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit_seq #(.N(N), .CNT_W(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model in plain arithmetic, RISC-V semantics.
    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIV:  return ovf ? a : 32'($signed(a) / $signed(b));
            OP_DIVU: return a / b;
            OP_REM:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [N-1:0] a,
                                      input logic [N-1:0] b);
        return (b == 0) ||
               ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one request; returns at the first negedge with resp_valid high.
    // lat counts rising edges after the accept edge until DONE is entered.
    task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] data, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1 check("req_ready before accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        data = resp_data;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid after transfer", resp_valid, 0);
        check("req_ready after transfer", req_ready, 1);
    endtask

    task automatic expect_op(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                             input logic [N-1:0] b, input logic [N-1:0] exp, input int exp_lat);
        logic [N-1:0] d;
        int l;
        run_op(op, a, b, d, l);
        check({tag, " data"}, d, exp);
        check({tag, " latency"}, l, exp_lat);
        release_resp();
    endtask

    initial begin
        logic [N-1:0] d, prev, ra, rb;
        logic [1:0]   rop;
        int           l;

        rstn       = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_data", resp_data, 0);
        check("reset busy", busy, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Directed arithmetic cases.
        expect_op("DIVU 100/7", OP_DIVU, 100, 7, 14, LAT);
        expect_op("REMU 100/7", OP_REMU, 100, 7, 2, LAT);
        expect_op("DIV -7/2", OP_DIV, -32'sd7, 2, 32'hFFFF_FFFD, LAT);
        expect_op("REM -7/2", OP_REM, -32'sd7, 2, 32'hFFFF_FFFF, LAT);
        expect_op("REM 7/-2", OP_REM, 7, -32'sd2, 1, LAT);
        expect_op("DIV -100/-7", OP_DIV, -32'sd100, -32'sd7, 14, LAT);

        // Special cases bypass the iteration: DONE right after the accept edge.
        expect_op("DIVU x/0", OP_DIVU, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 0);
        expect_op("REM 0x1234/0", OP_REM, 32'h1234, 0, 32'h1234, 0);
        expect_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        expect_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        expect_op("DIVU min/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, LAT);

        // Backpressure: result held while the consumer stalls.
        run_op(OP_DIVU, 100000, 7, d, l);
        check("bp first data", d, 14285);
        req_valid = 1'b1;
        req_op    = OP_REMU;
        req_a     = 50;
        req_b     = 8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp resp_valid held", resp_valid, 1);
            check("bp resp_data held", resp_data, 14285);
            check("bp req_ready low", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp transfer done", resp_valid, 0);
        check("bp no same-cycle accept", busy, 0);
        check("bp req_ready back", req_ready, 1);
        req_valid = 1'b0;
        expect_op("REMU after bp", OP_REMU, 50, 8, 2, LAT);

        // Flush mid-CALC: back to IDLE, no response, resp_data untouched.
        prev = 2;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_a     = 12345;
        req_b     = -32'sd3;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pre-flush no resp_valid", resp_valid, 0);
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush busy", busy, 0);
        check("flush resp_valid", resp_valid, 0);
        check("flush resp_data kept", resp_data, prev);
        check("flush blocks req_ready", req_ready, 0);
        flush = 1'b0;
        #1 check("req_ready after flush", req_ready, 1);
        expect_op("DIVU after flush", OP_DIVU, 1000, 10, 100, LAT);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_REMU;
        req_a     = 999;
        req_b     = 5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("busy before reset", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("async reset req_ready", req_ready, 1);
        check("async reset resp_valid", resp_valid, 0);
        check("async reset resp_data", resp_data, 0);
        check("async reset busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        expect_op("REMU after reset", OP_REMU, 999, 5, 4, LAT);

        // Random ops against the reference model.
        for (int n = 0; n < 500; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, d, l);
            check($sformatf("rand %0d op%0d %h/%h data", n, rop, ra, rb), d, model(rop, ra, rb));
            check($sformatf("rand %0d latency", n), l, is_special(rop, ra, rb) ? 0 : LAT);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_resp();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
